// File: rtl/encoder_4to2_pkg.sv
// Shared pattern constants, FSM state type and pattern-classification helpers
// for the 4-to-2 receive encoder.
package encoder_4to2_pkg;

  localparam logic [3:0] PAT_IDLE = 4'b0000;
  localparam logic [3:0] PAT_LO   = 4'b0011;
  localparam logic [3:0] PAT_HI   = 4'b1100;
  localparam logic [3:0] PAT_AMB  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Code {B,A} for a legal non-idle pattern; 1111 reports 01 with ambig set.
  function automatic logic [1:0] pat_code(input logic [3:0] pat);
    logic [1:0] code;
    case (pat)
      PAT_LO:  code = 2'b00;
      PAT_HI:  code = 2'b11;
      PAT_AMB: code = 2'b01;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  function automatic logic pat_legal(input logic [3:0] pat);
    logic legal;
    case (pat)
      PAT_LO, PAT_HI, PAT_AMB: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two capture stages; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/encoder_4to2_rx.sv
// Debounced 4-line pattern receiver emitting {B,A} tokens over a valid/ready handshake.
// Optional saturating illegal-pattern counter enabled by macro ENCODER_4TO2_ERRCNT_EN.
module encoder_4to2_rx
  import encoder_4to2_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inD,
  input  logic       inC,
  input  logic       inB,
  input  logic       inA,
  output logic [1:0] out_code,
  output logic       out_ambig,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [3:0] STABLE_W = 4'(STABLE_CYCLES);

  logic [3:0] samp_s;
  logic       change_s;
  logic       qual_s;
  logic [3:0] cnt_step_s;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       ambig_q, ambig_d;
  logic       err_q, err_d;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({inD, inC, inB, inA}),
    .q_o   (samp_s)
  );

  // A pattern qualifies on the exact sample where its run length reaches STABLE_CYCLES.
  assign change_s   = (samp_s != cand_q);
  assign qual_s     = change_s ? (STABLE_W == 4'd1) : (cnt_q == (STABLE_W - 4'd1));
  assign cnt_step_s = change_s ? 4'd1 : ((cnt_q == STABLE_W) ? cnt_q : (cnt_q + 4'd1));

  // Next-state logic; candidate and count stay frozen while a token is pending.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    valid_d    = valid_q;
    code_d     = code_q;
    ambig_d    = ambig_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_QUAL: begin
        cand_d = samp_s;
        cnt_d  = cnt_step_s;
        if (qual_s) begin
          if (samp_s == PAT_IDLE) begin
            last_vld_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (pat_legal(samp_s)) begin
            if (!last_vld_q || (last_q != samp_s)) begin
              state_d = ST_PEND;
              valid_d = 1'b1;
              code_d  = pat_code(samp_s);
              ambig_d = (samp_s == PAT_AMB);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (change_s) begin
          state_d = ST_QUAL;
        end else begin
          state_d = state_q;
        end
      end
      ST_PEND: begin
        if (valid_q && out_ready) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b0;
          code_d     = 2'b00;
          ambig_d    = 1'b0;
          last_d     = cand_q;
          last_vld_d = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        code_d  = 2'b00;
        ambig_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cand_q     <= PAT_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= PAT_IDLE;
      last_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= 2'b00;
      ambig_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      ambig_q    <= ambig_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_code  = code_q;
  assign out_ambig = ambig_q;
  assign err       = err_q;

`ifdef ENCODER_4TO2_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counter steps together with the err pulse and sticks at 255.
  always_comb begin
    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Illegal-pattern counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_encoder_4to2_rx.sv
// Randomized and directed bench for encoder_4to2_rx against a behavioural run-length model.
module tb_encoder_4to2_rx;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pat = 4'b0000;
  logic       out_ready = 1'b1;
  logic [1:0] out_code;
  logic       out_ambig;
  logic       out_valid;
  logic       err;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;

  string       nm_q[$];
  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];

  encoder_4to2_rx #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inD       (pat[3]),
    .inC       (pat[2]),
    .inB       (pat[1]),
    .inA       (pat[0]),
    .out_code  (out_code),
    .out_ambig (out_ambig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] sh [2];
  logic [3:0] m_cand, m_tok, m_last;
  logic       m_has_last, m_pend, m_err;
  int         m_run, m_errcnt;

  function automatic logic [1:0] enc(input logic [3:0] p);
    if (p == 4'b1100) return 2'b11;
    if (p == 4'b1111) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    forever begin
      logic [3:0] samp;
      logic reached;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sh[0] = 4'b0000; sh[1] = 4'b0000;
        m_cand = 4'b0000; m_run = 0; m_tok = 4'b0000;
        m_last = 4'b0000; m_has_last = 1'b0;
        m_pend = 1'b0; m_err = 1'b0; m_errcnt = 0;
      end else begin
        samp  = sh[1];
        sh[1] = sh[0];
        sh[0] = pat;
        m_err = 1'b0;
        if (m_pend) begin
          if (out_ready) begin
            m_pend = 1'b0; m_last = m_tok; m_has_last = 1'b1;
          end
        end else begin
          reached = 1'b0;
          if (samp != m_cand) begin
            m_cand = samp; m_run = 1; reached = (S == 1);
          end else if (m_run < S) begin
            m_run = m_run + 1; reached = (m_run == S);
          end
          if (reached) begin
            if (samp == 4'b0000) m_has_last = 1'b0;
            else if (samp == 4'b0011 || samp == 4'b1100 || samp == 4'b1111) begin
              if (!m_has_last || m_last != samp) begin
                m_pend = 1'b1; m_tok = samp;
              end
            end else begin
              m_err = 1'b1;
              if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
            end
          end
        end
      end
    end
  end

  // ---------------- single compare process ----------------
  initial begin
    forever begin
      logic [12:0] got, want;
      logic [7:0] want_cnt;
      @(negedge clk);
`ifdef ENCODER_4TO2_ERRCNT_EN
      want_cnt = 8'(m_errcnt);
`else
      want_cnt = 8'd0;
`endif
      want = {m_pend, (m_pend ? enc(m_tok) : 2'b00), (m_pend && m_tok == 4'b1111), m_err, want_cnt};
      got  = {out_valid, out_code, out_ambig, err, err_count};
      total = total + 1;
      if (got !== want) begin
        bad = bad + 1;
        $display("FAIL model t=%0t got{v,code,amb,err,cnt}=%h required=%h", $time, got, want);
      end
      while (nm_q.size() > 0) begin
        string nm;
        logic [31:0] a, e;
        nm = nm_q.pop_front();
        a  = act_q.pop_front();
        e  = exp_q.pop_front();
        total = total + 1;
        if (a !== e) begin
          bad = bad + 1;
          $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nm_q.push_back(nm);
    act_q.push_back(act);
    exp_q.push_back(exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] p, input int n);
    pat = p;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string nm, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int errs, vals, badcode;
    logic [3:0] table_p [5];
    table_p[0] = 4'b0000; table_p[1] = 4'b0011; table_p[2] = 4'b1100;
    table_p[3] = 4'b1111; table_p[4] = 4'b0101;

    rst_n = 1'b0; pat = 4'b0000; out_ready = 1'b1;
    step(); step();
    chk("reset_outputs", {19'd0, out_valid, out_code, out_ambig, err, err_count}, 32'd0);
    rst_n = 1'b1;
    settle(4'b0000, 8);

    // Illegal 0101 held 10+ cycles: one err pulse, no token.
    pat = 4'b0101; errs = 0; vals = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      errs += int'(err);
      vals += int'(out_valid);
    end
    chk("illegal_err_pulses", errs, 32'd1);
    chk("illegal_no_token", vals, 32'd0);
`ifdef ENCODER_4TO2_ERRCNT_EN
    chk("illegal_err_count", {24'd0, err_count}, 32'd1);
`else
    chk("illegal_err_count", {24'd0, err_count}, 32'd0);
`endif
    settle(4'b0000, 8);

    // 0011 changes before edge k: valid exactly after edge k+4, one cycle.
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lo_latency_low", {31'd0, out_valid}, 32'd0);
    end
    step();
    chk("lo_valid", {29'd0, out_valid, out_code}, 32'h4);
    chk("lo_ambig", {31'd0, out_ambig}, 32'd0);
    step();
    chk("lo_one_cycle", {31'd0, out_valid}, 32'd0);

    // 1111 with back-pressure, input switches to 1100 while pending.
    out_ready = 1'b0; pat = 4'b1111;
    wait_valid("amb_timeout", 12);
    chk("amb_token", {29'd0, out_valid, out_code}, 32'h5);
    pat = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("amb_held", {28'd0, out_valid, out_code, out_ambig}, 32'hB);
    end
    out_ready = 1'b1;
    step();
    chk("amb_accepted", {31'd0, out_valid}, 32'd0);
    wait_valid("hi_timeout", 12);
    chk("hi_token", {28'd0, out_valid, out_code, out_ambig}, 32'hE);
    settle(4'b0000, 8);

    // Glitch 0011 -> 0111 for one cycle mid-qualification.
    pat = 4'b0011; step(); step();
    pat = 4'b0111; step();
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("glitch_wait", {30'd0, out_valid, err}, 32'd0);
    end
    step();
    chk("glitch_token", {29'd0, out_valid, out_code}, 32'h4);
    settle(4'b0000, 8);

    // 0011 held, 0000, 0011 again -> exactly two tokens.
    vals = 0; badcode = 0;
    for (int i = 0; i < 28; i++) begin
      pat = (i >= 10 && i < 18) ? 4'b0000 : 4'b0011;
      step();
      if (out_valid) begin
        vals++;
        if (out_code != 2'b00) badcode++;
      end
    end
    chk("resend_tokens", vals, 32'd2);
    chk("resend_codes", badcode, 32'd0);
    settle(4'b0000, 8);

    // Reset while pending discards the token; re-qualification takes full latency.
    out_ready = 1'b0; pat = 4'b0011;
    wait_valid("pend_timeout", 12);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_low", {31'd0, out_valid}, 32'd0);
    end
    step();
    chk("post_reset_token", {29'd0, out_valid, out_code}, 32'h4);

    // Randomized segments, compared every cycle against the model.
    for (int seg = 0; seg < 80; seg++) begin
      int hold;
      if ($urandom_range(0, 3) == 0) pat = 4'($urandom_range(0, 15));
      else pat = table_p[$urandom_range(0, 4)];
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (seg == 40 && c == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        step();
      end
    end
    rst_n = 1'b1;
    settle(4'b0000, 6);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/encoder_4to2_rx.md
ENCODER_4TO2_RX -- requirements
Module: encoder_4to2_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, range 1..15: consecutive synchronized samples needed to qualify a pattern.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports inD, inC, inB, inA  input  1 each  four-line pattern, asynchronous to clk.
REQ-005 SHALL have port out_code  output  2  encoded code {B,A}.
REQ-006 SHALL have port out_ambig  output  1  token came from pattern 1111 (code 01 or 10, not resolvable).
REQ-007 SHALL have port out_valid  output  1  token available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts token.
REQ-009 SHALL have port err  output  1  one-cycle pulse on a qualified illegal pattern.
REQ-010 SHALL have port err_count  output  8  saturating illegal-pattern count (macro-dependent, REQ-027).

Function
REQ-011 SHALL pass each input line through a 2-flop synchronizer before any use.
REQ-012 SHALL map {D,C,B,A}: 0011 -> code 00, ambig 0; 1100 -> code 11, ambig 0; 1111 -> code 01, ambig 1; 0000 -> idle; all else illegal.
REQ-013 SHALL track a candidate pattern and count; a differing synchronized sample reloads candidate and sets count to 1.
REQ-014 SHALL qualify a pattern stable for STABLE_CYCLES samples; for input changing before edge k and then held, out_valid rises after edge k+1+STABLE_CYCLES.
REQ-015 SHALL implement states IDLE, QUAL, PEND: IDLE -> QUAL on any sample change; QUAL -> PEND on qualified legal non-idle pattern differing from last-emitted; QUAL -> IDLE on qualified idle, illegal, or repeat pattern; PEND -> IDLE on out_valid && out_ready.
REQ-016 SHALL hold out_valid high and out_code/out_ambig constant while out_valid && !out_ready.
REQ-017 SHALL ignore input changes in PEND; after handshake, a held pattern equal to the emitted one SHALL NOT re-emit, a changed one SHALL be re-qualified from count 1.
REQ-018 SHALL record the last-emitted pattern on handshake; a qualified 0000 SHALL clear it so the same code may be sent again.
REQ-019 SHALL pulse err for one cycle per qualified illegal pattern, not repeated while it stays held.
REQ-020 SHALL, with out_ready held high, deassert out_valid on the cycle after the accepting edge (one token per handshake).
REQ-021 SHALL drive out_code 00, out_ambig 0 whenever out_valid is low.

Reset
REQ-022 SHALL on rst_n low immediately force: state IDLE, synchronizers 0000, candidate 0000, count 0, last-emitted none, out_valid 0, out_code 00, out_ambig 0, err 0, err_count 0.
REQ-023 SHALL discard a pending token when reset asserts in PEND; no token after release without a fresh qualification.
REQ-024 SHALL deassert reset effects synchronously at the first clk edge after rst_n rises.

Configuration
REQ-025 SHALL use macro ENCODER_4TO2_ERRCNT_EN.
REQ-026 SHALL, when defined, increment err_count on each err pulse, saturating at 255.
REQ-027 SHALL, when undefined, tie err_count to 0 with no counter flops; err unaffected.

Structure
REQ-028 SHALL place pattern constants (PAT_IDLE 0000, PAT_LO 0011, PAT_HI 1100, PAT_AMB 1111) and the state enum in shared package encoder_4to2_pkg.
REQ-029 SHALL instantiate sub-module sync_2ff (4 bits wide) for the synchronizer; the rest stays flat.

Verification
REQ-030 SHALL cover: STABLE_CYCLES=3, ready=1, drive 0011 held -> one token code 00 ambig 0, out_valid after edge k+4, high one cycle.
REQ-031 SHALL cover: drive 1111, ready=0 for 5 cycles then 1, change input to 1100 meanwhile -> code 01 ambig 1 held stable until accept; then token 11.
REQ-032 SHALL cover: 0011 glitches to 0111 for 1 cycle mid-qualification -> no err, 0011 qualifies 3 samples after glitch ends.
REQ-033 SHALL cover: 0101 held 10 cycles -> single err pulse, no token, err_count 1 (macro on) / 0 (macro off).
REQ-034 SHALL cover: 0011 emitted, held, then 0000, then 0011 -> exactly two tokens code 00.
REQ-035 SHALL cover: rst_n low for 1 cycle while in PEND -> out_valid 0 immediately, no token until re-qualification.
